// File: rtl/lsu.sv
// Load/store unit: one memory op at a time over a valid/ready word bus,
// with store byte-lane replication and load sign/zero extension.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_write,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        illegal;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] byte_sh, half_sh;
  logic [31:0] ld_data;

  always_comb begin
    illegal = 1'b0;
    case (mem_op)
      3'b000, 3'b100: illegal = mem_write & mem_op[2];
      3'b001, 3'b101: illegal = addr[0] | (mem_write & mem_op[2]);
      3'b010:         illegal = (addr[1:0] != 2'b00);
      default:        illegal = 1'b1;
    endcase
  end

  // Store lanes are computed at acceptance so the bus fields stay frozen in REQ.
  always_comb begin
    st_strb = 4'b1111;
    st_data = wdata;
    case (mem_op[1:0])
      2'b00: begin
        st_strb = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_strb = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata;
      end
    endcase
  end

  always_comb begin
    byte_sh = bus_rdata >> {addr_q[1:0], 3'b000};
    half_sh = bus_rdata >> {addr_q[1], 4'b0000};
    case (op_q)
      3'b000:  ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  ld_data = {24'd0, byte_sh[7:0]};
      3'b001:  ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  ld_data = {16'd0, half_sh[15:0]};
      default: ld_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = mem_write;
          op_d    = mem_op;
          addr_d  = addr;
          wdata_d = st_data;
          wstrb_d = mem_write ? st_strb : 4'b0000;
          if (illegal) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus_req_ready) state_d = RESP;
      end
      RESP: begin
        if (bus_resp_valid) begin
          if (!we_q) rdata_d = ld_data;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'b0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign bus_req_valid = (state_q == REQ);
  assign bus_we        = we_q;
  assign bus_addr      = {addr_q[31:2], 2'b00};
  assign bus_wdata     = wdata_q;
  assign bus_wstrb     = wstrb_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-cycle-style RISC-V core. It executes the memory side of the control decoder's `mem_write`/`mem_op` encoding against a word-wide valid/ready data bus. It produces byte strobes and replicated write data for stores, and extracts and sign- or zero-extends load data. The core stalls on `req_ready`/`done`, and the result feeds the `wd_src = 1xx` (mem) writeback path.

## Interface
- No parameters. Data and address widths are fixed at 32.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset; one clock, reset is asynchronous and active-high.
- `req_valid` in 1: core presents a memory operation.
- `req_ready` out 1: unit idle, can accept; equals (state == IDLE).
- `mem_write` in 1: 1 = store, 0 = load.
- `mem_op` in 3: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned. For stores, only 000/001/010 are legal.
- `addr` in 32: byte address.
- `wdata` in 32: store data (low bits significant).
- `done` out 1: one-cycle pulse, operation finished.
- `err` out 1: valid with `done`; 1 = misaligned address or illegal `mem_op`.
- `rdata` out 32: extended load result; valid with `done`; holds until next `done`.
- `bus_req_valid` out 1: bus request.
- `bus_req_ready` in 1: bus accepts request.
- `bus_we` out 1: write request.
- `bus_addr` out 32: `{addr[31:2],2'b00}`.
- `bus_wdata` out 32: replicated store data.
- `bus_wstrb` out 4: byte strobes (0000 on reads).
- `bus_resp_valid` in 1: bus response (reads and writes).
- `bus_rdata` in 32: read word, valid with `bus_resp_valid`.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: `req_ready=1`. On `req_valid`, latch `mem_write`, `mem_op`, `addr`, `wdata`.
  - If illegal, go to IDLE and register `done=1, err=1` for the next cycle. No bus activity.
  - Otherwise go to REQ.
- Illegal means any of the following:
  - `mem_op` in {011,110,111};
  - store with `mem_op[2]=1`;
  - half access with `addr[0]=1`;
  - word access with `addr[1:0]!=0`.
- REQ: `bus_req_valid=1`, with `bus_we`/`bus_addr`/`bus_wdata`/`bus_wstrb` driven from the latched request and held stable. On `bus_req_ready`, go to RESP.
- RESP: `bus_req_valid=0`. On `bus_resp_valid`:
  - register `rdata` (loads only; stores leave `rdata` unchanged);
  - pulse `done=1, err=0`;
  - go to IDLE.
- `bus_resp_valid` is ignored outside RESP.
- Store encoding:
  - sb: wstrb = `4'b0001 << addr[1:0]`, wdata = `{4{wdata[7:0]}}`;
  - sh: wstrb = `addr[1] ? 1100 : 0011`, wdata = `{2{wdata[15:0]}}`;
  - sw: wstrb = 1111, wdata = `wdata`.
- Load extraction:
  - byte = `bus_rdata[8*addr[1:0] +: 8]`;
  - half = `bus_rdata[16*addr[1] +: 16]`;
  - signed ops sign-extend to 32; unsigned ops zero-extend; word passes through.
- Reset (async, any state): FSM to IDLE; `done=0`, `err=0`, `rdata=0`, `bus_req_valid=0`, `bus_wstrb=0`, `bus_we=0`. `req_ready=1` follows from IDLE.
  - An in-flight transaction is abandoned with no `done`.
  - A stale `bus_resp_valid` after reset is ignored.

## Timing
- Request accepted at edge T.
- `bus_req_valid` high from cycle T+1.
  - If `bus_req_ready` is high in cycle T+1, the unit is in RESP from T+2.
  - Otherwise the request is held until ready.
- Response: `bus_resp_valid` sampled at edge E gives `done`/`rdata` valid in cycle E+1 (registered). `req_ready=1` in that same cycle, so a back-to-back request is accepted at the end of cycle E+1.
- Minimum latency: request acceptance to `done` = 3 cycles, when ready and response are immediate.
- Error path: `done=err=1` in cycle T+1; `req_ready=1` throughout.
- `done` is never high for two consecutive cycles from a single request.
- `req_valid` while not IDLE is ignored and not queued.

## Test plan
- Load-byte signed: lb at addr 0x1003, bus_rdata 0x80FF_1234 returned the cycle after the request handshake.
  - Required: bus_addr=0x1000, wstrb=0000, bus_we=0.
  - Required: done with rdata=0xFFFF_FF80 and err=0, 3 cycles after acceptance.
- Unsigned/half variants on the same word 0x80FF_1234:
  - lbu addr 0x1003 → 0x0000_0080;
  - lh addr 0x1002 → 0xFFFF_80FF;
  - lhu addr 0x1000 → 0x0000_1234;
  - lw addr 0x1000 → 0x80FF_1234.
- Stores with wdata=0xAABB_CCDD:
  - sb addr 0x2002 → wstrb=0100, bus_wdata=0xDDDD_DDDD;
  - sh addr 0x2002 → wstrb=1100, bus_wdata=0xCCDD_CCDD;
  - sw addr 0x2000 → wstrb=1111, bus_wdata=0xAABB_CCDD;
  - in all cases, done arrives after bus_resp_valid and rdata is unchanged.
- Misaligned and illegal requests:
  - lw addr 0x1002, sh addr 0x1001, and load `mem_op`=011 each give done=1, err=1 in T+1;
  - bus_req_valid never asserts;
  - a legal request issued the next cycle is accepted.
- Backpressure: bus_req_ready held low 5 cycles, then bus_resp_valid delayed 4 cycles.
  - Required: bus request fields stable throughout, req_ready=0, exactly one done pulse.
  - Required: a req_valid pulse mid-transaction is ignored.
- Reset mid-operation: assert rst while in RESP, then drive bus_resp_valid after release.
  - Required: outputs go to reset values immediately on rst assertion; no done pulse is produced; req_ready=1.
